// File: rtl/player_ctrl.sv
// player_ctrl: frame-ticked player movement, jump and hit FSM feeding a sprite core.
// Optional shot logic is built only when PLAYER_FIRE_EN is defined.
module player_ctrl #(
  parameter int H_RES      = 640,
  parameter int SIZE       = 32,
  parameter int GROUND_Y   = 416,
  parameter int SPAWN_X    = 16,
  parameter int STEP       = 2,
  parameter int JUMP_V     = 12,
  parameter int HIT_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  input  logic        btn_fire,
  input  logic        hit,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [4:0]  ctrl,
  output logic [1:0]  state,
  output logic        fire_pulse
);
  typedef enum logic [1:0] {IDLE = 2'b00, WALK = 2'b01, JUMP = 2'b10, HIT = 2'b11} state_e;
  localparam int CW = $clog2(HIT_FRAMES + 1);
  localparam logic [10:0] X_MAX = 11'(H_RES - SIZE);
  localparam logic [10:0] GY = 11'(GROUND_Y);
  state_e state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d, x_mv;
  logic signed [5:0] vy_q, vy_d, vy_cur, vy_inc;
  logic signed [12:0] y_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] ctrl_q, ctrl_d;
  logic hp_q, hp_d, arm_q, arm_d;
  logic go_l, go_r, hit_now, grounded, start, airborne, jumping, land, fire_id, hit_ph;
  assign go_l = btn_left & ~btn_right;
  assign go_r = btn_right & ~btn_left;
  assign x_mv = go_l ? (x_q < 11'(STEP) ? 11'd0 : x_q - 11'(STEP)) :
                go_r ? (x_q > X_MAX - 11'(STEP) ? X_MAX : x_q + 11'(STEP)) : x_q;
  assign hit_now = hp_q | hit;
  assign grounded = state_q == IDLE || state_q == WALK;
  assign start = grounded & btn_jump & arm_q & ~hit_now;
  assign airborne = y_q != GY;
  assign jumping = start | (state_q == JUMP) | (state_q == HIT & airborne);
  assign vy_cur = start ? $signed(6'(-JUMP_V)) : vy_q;
  assign vy_inc = vy_cur == 6'sd31 ? vy_cur : vy_cur + 6'sd1;
  assign y_nx = $signed({2'b00, y_q}) + 13'(vy_cur);
  assign land = y_nx >= $signed(13'(GROUND_Y));
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    vy_d = vy_q;
    cnt_d = cnt_q;
    hp_d = hp_q | hit;
    arm_d = arm_q;
    if (frame_tick) begin
      hp_d = 1'b0;
      if (grounded) arm_d = start ? 1'b0 : (arm_q | ~btn_jump);
      if (jumping) begin
        y_d = land ? GY : y_nx[10:0];
        vy_d = land ? 6'sd0 : vy_inc;
      end
      if (hit_now) begin
        state_d = HIT;
        cnt_d = CW'(HIT_FRAMES - 1);
      end else if (state_q == HIT) begin
        if (cnt_q == '0) state_d = (jumping && !land) ? JUMP : IDLE;
        else cnt_d = cnt_q - 1'b1;
      end else begin
        x_d = x_mv;
        state_d = (jumping && !land) ? JUMP : (go_l | go_r) ? WALK : IDLE;
      end
    end
    // Colour phase counts frames elapsed in HIT, so a reload restarts it at 01
    hit_ph = 1'((CW'(HIT_FRAMES - 1) - cnt_d) >> 2);
    ctrl_d = state_d == HIT ? {hit_ph ? 2'b11 : 2'b01, 3'b000} :
             state_d == WALK ? 5'b00100 : state_d == JUMP ? 5'b00010 : 5'b00000;
    if (fire_id && state_d != HIT) ctrl_d[1:0] = 2'b11;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= 11'(SPAWN_X);
      y_q <= GY;
      vy_q <= 6'sd0;
      cnt_q <= '0;
      hp_q <= 1'b0;
      arm_q <= 1'b1;
      ctrl_q <= 5'b00000;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      vy_q <= vy_d;
      cnt_q <= cnt_d;
      hp_q <= hp_d;
      arm_q <= arm_d;
      ctrl_q <= ctrl_d;
    end
  end
`ifdef PLAYER_FIRE_EN
  logic [3:0] fcnt_q, fcnt_d;
  logic fprev_q, fprev_d, fire_q, fire_d;
  always_comb begin
    fcnt_d = fcnt_q;
    fprev_d = fprev_q;
    fire_d = 1'b0;
    if (frame_tick) begin
      fprev_d = btn_fire;
      fire_d = btn_fire & ~fprev_q & (fcnt_q == 4'd0) & ~hit_now & (state_q != HIT);
      fcnt_d = fire_d ? 4'd8 : (fcnt_q != 4'd0 ? fcnt_q - 4'd1 : 4'd0);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= 4'd0;
      fprev_q <= 1'b0;
      fire_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      fprev_q <= fprev_d;
      fire_q <= fire_d;
    end
  end
  assign fire_id = fcnt_d != 4'd0;
  assign fire_pulse = fire_q;
`else
  logic unused_fire;
  assign unused_fire = btn_fire;
  assign fire_id = 1'b0;
  assign fire_pulse = 1'b0;
`endif
  assign x0 = x_q;
  assign y0 = y_q;
  assign ctrl = ctrl_q;
  assign state = state_q;
endmodule
